// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle integer divide/remainder unit for the EX stage.
// Runs a restoring shift-subtract divider, one quotient bit per cycle, MSB first.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
//
// Ports:
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : synchronous active-high reset
//   start_i    : EX holds a valid divide/remainder instruction
//   op_i       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i : operand 1 (rs1)
//   divisor_i  : operand 2 (rs2)
//   kill_i     : EX flush, aborts any operation
//   busy_o     : combinational stall request to the pipeline controller
//   valid_o    : result_o valid this cycle
//   result_o   : registered quotient or remainder
module div_sequencer #(
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DWIDTH-1:0] dividend_i,
   input  logic [DWIDTH-1:0] divisor_i,
   input  logic              kill_i,
   output logic              busy_o,
   output logic              valid_o,
   output logic [DWIDTH-1:0] result_o
);

   localparam int unsigned CW = $clog2(DWIDTH) + 1;
   localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DWIDTH-1:0] quo_q, rem_q, dsr_q, result_q;
   logic [CW-1:0]     cnt_q;
   logic              neg_quo_q, neg_rem_q, is_rem_q;

   // Accept-time decode
   logic              accept, special;
   logic              is_signed, is_rem_op, a_neg, b_neg, div_zero, overflow;
   logic [DWIDTH-1:0] a_abs, b_abs, special_res;

   // One restoring step
   logic [DWIDTH:0]   partial, diff;
   logic              ge;
   logic [DWIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;

   always_comb begin
      is_signed   = ~op_i[0];
      is_rem_op   = op_i[1];
      a_neg       = is_signed & dividend_i[DWIDTH-1];
      b_neg       = is_signed & divisor_i[DWIDTH-1];
      a_abs       = a_neg ? (DWIDTH'(0) - dividend_i) : dividend_i;
      b_abs       = b_neg ? (DWIDTH'(0) - divisor_i) : divisor_i;
      div_zero    = (divisor_i == '0);
      overflow    = is_signed & (dividend_i == MOST_NEG) & (divisor_i == '1);
      special     = div_zero | overflow;
      accept      = (state_q == IDLE) & start_i & ~kill_i & ~rst_i;
      // Divide by zero: quotient all-ones, remainder is the dividend.
      // Overflow: quotient most-negative, remainder zero.
      if (div_zero) special_res = is_rem_op ? dividend_i : '1;
      else          special_res = is_rem_op ? '0 : MOST_NEG;
   end

   // Shift in the next dividend bit and subtract if the divisor fits.
   always_comb begin
      partial  = {rem_q, quo_q[DWIDTH-1]};
      diff     = partial - {1'b0, dsr_q};
      ge       = ~diff[DWIDTH];
      rem_step = ge ? diff[DWIDTH-1:0] : partial[DWIDTH-1:0];
      quo_step = {quo_q[DWIDTH-2:0], ge};
      quo_fix  = neg_quo_q ? (DWIDTH'(0) - quo_step) : quo_step;
      rem_fix  = neg_rem_q ? (DWIDTH'(0) - rem_step) : rem_step;
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and combinational handshake outputs
   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               busy_o  = 1'b1;
               state_d = special ? DONE : BUSY;
            end
         end
         BUSY: begin
            busy_o = 1'b1;
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            valid_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Flush wins over everything and suppresses both handshakes.
      if (kill_i) begin
         state_d = IDLE;
         busy_o  = 1'b0;
         valid_o = 1'b0;
      end
      if (rst_i) begin
         busy_o  = 1'b0;
         valid_o = 1'b0;
      end
   end

   // Datapath: operand latch at accept, one step per BUSY cycle, result on finish
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         quo_q     <= '0;
         rem_q     <= '0;
         dsr_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
      end else if (accept) begin
         if (special) begin
            result_q <= special_res;
         end else begin
            quo_q     <= a_abs;
            rem_q     <= '0;
            dsr_q     <= b_abs;
            cnt_q     <= CW'(DWIDTH);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            is_rem_q  <= is_rem_op;
         end
      end else if ((state_q == BUSY) && !kill_i) begin
         quo_q <= quo_step;
         rem_q <= rem_step;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) result_q <= is_rem_q ? rem_fix : quo_fix;
      end
   end

   assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed, table-driven bench for div_sequencer (DWIDTH=32).
module tb_div_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        kill_i;
   logic        busy_o;
   logic        valid_o;
   logic [31:0] result_o;

   int errors = 0;
   int checks = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   div_sequencer #(.DWIDTH(32)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .kill_i     (kill_i),
      .busy_o     (busy_o),
      .valid_o    (valid_o),
      .result_o   (result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 0x%h expected 0x%h", name, tag, act, exp);
      end
   endtask

   // Drive an instruction in the current cycle (T) and check the accept stall.
   task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int tag);
      op_i = op; dividend_i = a; divisor_i = b; start_i = 1'b1;
      #1;
      chk("busy_at_accept", tag, 32'(busy_o), 32'd1);
      chk("valid_at_accept", tag, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      start_i = 1'b0;
      #1;
   endtask

   // Called at T+1: wait (bounded) for valid_o and check latency, stall length and result.
   task automatic await_result(input logic [31:0] exp, input bit special, input int tag);
      int lat;
      int nbusy;
      bit got;
      lat = 1; nbusy = 0; got = 0;
      while (!got && lat <= 40) begin
         if (valid_o) got = 1;
         else begin
            if (busy_o) nbusy++;
            @(negedge clk_i); #1;
            lat++;
         end
      end
      chk("valid_seen", tag, 32'(got), 32'd1);
      chk("latency", tag, 32'(lat), special ? 32'd1 : 32'd33);
      chk("busy_cycles_after_T", tag, 32'(nbusy), special ? 32'd0 : 32'd32);
      chk("result", tag, result_o, exp);
      chk("busy_in_done", tag, 32'(busy_o), 32'd0);
      @(negedge clk_i); #1;
      chk("done_one_cycle", tag, 32'(valid_o), 32'd0);
   endtask

   initial begin
      int nvalid;
      vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
      vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
      vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
      vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
      vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
      vecs[5]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[6]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1'b1};
      vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
      vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
      vecs[9]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
      vecs[10] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b1};
      vecs[11] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[12] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
      vecs[13] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0};
      vecs[14] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
      vecs[15] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0};

      rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = 2'b00;
      dividend_i = '0; divisor_i = '0;
      repeat (2) @(negedge clk_i);
      // Reset held with start asserted: no stall, no valid.
      start_i = 1'b1; #1;
      chk("busy_in_reset", 0, 32'(busy_o), 32'd0);
      chk("valid_in_reset", 0, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0; start_i = 1'b0; #1;
      chk("reset_result", 0, result_o, 32'd0);
      chk("reset_busy", 0, 32'(busy_o), 32'd0);
      chk("reset_valid", 0, 32'(valid_o), 32'd0);

      for (int i = 0; i < NVEC; i++) begin
         accept(vecs[i].op, vecs[i].a, vecs[i].b, i);
         await_result(vecs[i].exp, vecs[i].special, i);
      end

      // Kill at T+10 of a DIVU, then DIVU 9/3 accepted at T+11.
      accept(OP_DIVU, 32'd100, 32'd7, 100);
      for (int c = 1; c < 10; c++) begin
         chk("no_valid_before_kill", 100 + c, 32'(valid_o), 32'd0);
         @(negedge clk_i); #1;
      end
      kill_i = 1'b1; #1;
      chk("busy_during_kill", 100, 32'(busy_o), 32'd0);
      chk("valid_during_kill", 100, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      kill_i = 1'b0; #1;
      accept(OP_DIVU, 32'd9, 32'd3, 111);
      await_result(32'd3, 1'b0, 111);

      // Reset at T+5 of a DIV: operation abandoned, result cleared.
      accept(OP_DIV, 32'd100, 32'd7, 200);
      repeat (4) begin @(negedge clk_i); #1; end
      rst_i = 1'b1; #1;
      chk("busy_mid_reset", 200, 32'(busy_o), 32'd0);
      chk("valid_mid_reset", 200, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0; #1;
      chk("result_after_mid_reset", 200, result_o, 32'd0);
      chk("busy_after_mid_reset", 200, 32'(busy_o), 32'd0);
      nvalid = 0;
      repeat (40) begin
         if (valid_o) nvalid++;
         @(negedge clk_i); #1;
      end
      chk("no_valid_after_reset", 200, 32'(nvalid), 32'd0);

      // start held high: ignored in DONE, re-accepted in the following IDLE cycle.
      op_i = OP_DIVU; dividend_i = 32'd5; divisor_i = 32'd0; start_i = 1'b1; #1;
      chk("held_busy_T", 300, 32'(busy_o), 32'd1);
      @(negedge clk_i); #1;
      chk("held_valid_T1", 300, 32'(valid_o), 32'd1);
      chk("held_busy_T1", 300, 32'(busy_o), 32'd0);
      @(negedge clk_i); #1;
      chk("held_busy_T2", 300, 32'(busy_o), 32'd1);
      chk("held_valid_T2", 300, 32'(valid_o), 32'd0);
      @(negedge clk_i); #1;
      chk("held_valid_T3", 300, 32'(valid_o), 32'd1);
      chk("held_result_T3", 300, result_o, 32'hFFFF_FFFF);
      start_i = 1'b0;
      @(negedge clk_i); #1;

      // Kill in DONE suppresses valid_o.
      accept(OP_REMU, 32'd5, 32'd0, 400);
      kill_i = 1'b1; #1;
      chk("valid_killed_in_done", 400, 32'(valid_o), 32'd0);
      @(negedge clk_i);
      kill_i = 1'b0; #1;
      chk("valid_after_done_kill", 400, 32'(valid_o), 32'd0);
      chk("busy_after_done_kill", 400, 32'(busy_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, operand/result width; counter width SHALL be $clog2(DWIDTH)+1.
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start_i  input  1  EX holds a valid divide/remainder instruction.
REQ-005 The block SHALL have port op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL have port dividend_i  input  DWIDTH  operand 1 (rs1).
REQ-007 The block SHALL have port divisor_i  input  DWIDTH  operand 2 (rs2).
REQ-008 The block SHALL have port kill_i  input  1  EX flush; aborts any operation.
REQ-009 The block SHALL have port busy_o  output  1  stall request to the pipeline controller (feeds stall_ex).
REQ-010 The block SHALL have port valid_o  output  1  result_o valid this cycle.
REQ-011 The block SHALL have port result_o  output  DWIDTH  quotient or remainder.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-013 Accept SHALL occur in IDLE when start_i=1 and kill_i=0; operands and op_i SHALL be sampled only at accept.
REQ-014 On accept with divisor_i=0, or with op DIV/REM, dividend_i=most-negative and divisor_i=all-ones (overflow), the next state SHALL be DONE (special path).
REQ-015 On any other accept, the block SHALL latch |dividend| and |divisor| (absolute value only for DIV/REM), the sign flags and op, load the counter with DWIDTH, and enter BUSY.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first and decrementing the counter; when the counter reaches 1 the next state SHALL be DONE (exactly DWIDTH BUSY cycles).
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE; start_i SHALL be ignored in DONE.
REQ-018 busy_o SHALL be combinational: 1 in IDLE when accept occurs, 1 in BUSY, 0 in DONE; busy_o SHALL be 0 whenever kill_i=1 or rst_i=1.
REQ-019 valid_o SHALL be 1 exactly when state=DONE and kill_i=0.
REQ-020 Normal latency: accept at cycle T -> busy_o high T..T+DWIDTH, valid_o at T+DWIDTH+1; special latency: busy_o high at T only, valid_o at T+1.
REQ-021 Signed quotient SHALL be negated when operand signs differ; signed remainder SHALL take the dividend's sign; unsigned ops SHALL use no sign correction.
REQ-022 Divide by zero SHALL give DIV/DIVU=all-ones, REM/REMU=dividend.
REQ-023 Overflow SHALL give DIV=most-negative, REM=0.
REQ-024 result_o SHALL be registered and hold its value outside DONE; it is meaningful only when valid_o=1.
REQ-025 kill_i=1 SHALL force next state IDLE from any state, with priority over start_i; no valid_o SHALL follow a killed operation.
REQ-026 An accept SHALL be possible in the IDLE cycle immediately after DONE or after a kill.

Reset
REQ-027 With rst_i=1 at a clock edge, state SHALL become IDLE, the counter, the latched operands and result_o SHALL become 0, and all sign flags SHALL be cleared.
REQ-028 While rst_i=1, busy_o and valid_o SHALL be 0; reset SHALL win over start_i and kill_i.
REQ-029 Reset mid-BUSY SHALL abandon the operation with no later valid_o.

Verification
REQ-030 DWIDTH=32, DIVU 100/7, accept at T -> busy_o high T..T+32, valid_o only at T+33, result_o=14; REMU same -> 2.
REQ-031 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-032 DIVU 5/0 -> valid_o at T+1, result_o=0xFFFFFFFF; REMU 5/0 -> 5; busy_o high only at T.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> valid_o at T+1, result_o=0x80000000; REM same -> 0.
REQ-034 kill_i at T+10 of DIVU -> busy_o 0 that cycle, IDLE at T+11, no valid_o; new DIVU 9/3 accepted at T+11 -> 3 at T+44.
REQ-035 rst_i at T+5 of DIV -> busy_o and valid_o 0 from T+5, state IDLE, result_o=0; no valid_o until a new accept.
